multi_channel_data_sync: RTL and testbench
==========================================

# multi_channel_data_sync

Parametrised successor to the single-bus data synchronizer. It carries NUM_CH independent bus/enable pairs from foreign clock domains into the CLK domain. Each enable passes through a NUM_STAGES flop chain, with per-channel edge detection selectable between level and toggle signalling. Captured words are presented per channel and also merged into one round-robin valid/ready stream that tags each word with its channel and flags overruns. The block sits at the receive side of every multi-source CDC crossing into the system clock domain.

## Interface
Parameters:
- BUS_WIDTH, 8: data bits per channel.
- NUM_STAGES, 2: synchronizer flops per enable; legal values are ≥2.
- NUM_CH, 4: channel count; legal values are ≥2.
- CH_W, $clog2(NUM_CH): channel-ID width, derived; do not override.

Ports:
- CLK  in  1  destination clock; the only clock.
- RST  in  1  reset; synchronous, active-low.
- Unsync_bus  in  NUM_CH*BUS_WIDTH  source data; channel c occupies bits [c*BUS_WIDTH +: BUS_WIDTH].
- bus_enable  in  NUM_CH  per-channel source qualifier, asynchronous to CLK.
- toggle_mode  in  1  0 = level mode (event on rising edge of synced enable); 1 = toggle mode (event on either edge); quasi-static.
- out_ready  in  1  merged-stream consumer ready.
- overrun_clr  in  1  one-cycle pulse; clears all overrun flags.
- sync_bus  out  NUM_CH*BUS_WIDTH  per-channel captured data.
- enable_pulse  out  NUM_CH  one-cycle capture strobe per channel.
- out_valid  out  1  merged word available.
- out_data  out  BUS_WIDTH  merged word.
- out_ch  out  CH_W  channel that produced out_data.
- overrun  out  NUM_CH  sticky per-channel overrun flags.

## Operation
- Per channel c:
  - bus_enable[c] is shifted through the NUM_STAGES flops and then one extra flop (prev).
  - event_c is sync & !prev in level mode, and sync ^ prev in toggle mode.
  - On event_c: enable_pulse[c] is set to 1 for one cycle, sync_bus[c] captures Unsync_bus[c], and pending[c] is set.
  - With no event, sync_bus[c] holds its value.
- Merge stage:
  - The output register loads when out_valid is 0, or when out_valid and out_ready are both 1.
  - On a load, the arbiter grants the first pending channel, searching upward from rr_ptr+1 with wrap-around.
  - The grant does three things: out_data takes sync_bus of that channel, out_ch takes the channel index, and pending for that channel is cleared. rr_ptr then takes the granted index.
  - If no channel is pending at a load opportunity, out_valid is cleared to 0.
  - While out_valid=1 and out_ready=0, out_data and out_ch hold stable.
- Boundary rules:
  - Event while pending[c] is already set and not granted in the same cycle: sync_bus[c] is overwritten (latest data wins) and overrun[c] is set.
  - Event in the same cycle that channel c is granted: the old word goes out, pending[c] stays 1 for the new word, and overrun is not set.
  - Events on several channels in the same cycle are all captured; the arbiter serialises them in round-robin order.
  - overrun_clr in the same cycle as an overrun set: the set wins for that channel.
  - A change of toggle_mode never generates an event by itself; it only changes the edge-detect function.
- Reset (RST=0 sampled at posedge CLK) clears the following to 0: every synchronizer flop, prev, sync_bus, enable_pulse, pending, out_valid, out_data, out_ch and overrun. rr_ptr resets to NUM_CH-1, so channel 0 has first priority. Reset mid-transfer discards all pending words.

## Timing
- Capture latency: enable_pulse[c] and the new sync_bus[c] appear NUM_STAGES+1 CLK edges after the first edge that samples the new bus_enable level. With NUM_STAGES=2, that is 3 edges.
- Unsync_bus[c] must be stable from the source enable change until enable_pulse[c] asserts.
- Merge latency: out_valid rises one edge after enable_pulse when the output register is free.
- Throughput: one merged word per cycle while out_ready=1.
- Per-channel rate limit: one event per NUM_STAGES+2 cycles without overrun, provided the merge stage keeps up.

## Configuration
- DSYNC_OVERRUN_EN defined: overrun flags, their set/clear logic and overrun_clr are implemented as above.
- DSYNC_OVERRUN_EN undefined: overrun is tied to 0 and overrun_clr is ignored. Overwrite-on-pending behaviour is unchanged.

## Test plan
- Reset, then level mode with bus_enable[1] 0→1 and Unsync_bus ch1 = 0xA5:
  - enable_pulse[1] is high for exactly 1 cycle, 3 edges after sampling.
  - sync_bus ch1 = 0xA5.
  - Next edge: out_valid=1, out_data=0xA5, out_ch=1.
- Toggle mode with bus_enable[2] toggling 0→1, then 1→0, 10 cycles apart, data 0x11 then 0x22: two pulses, and the merged stream delivers 0x11 then 0x22 on ch2. The same pattern in level mode gives one pulse only.
- Events on ch0, ch1 and ch3 in the same cycle with out_ready=1 from reset: out_ch sequence is 0, 1, 3 on consecutive cycles, and out_valid drops afterwards.
- out_ready=0 with ch0 events carrying 0x01 then 0x02:
  - out_data holds 0x01.
  - overrun[0] stays 0, because 0x02 is only pending.
  - A third event 0x03 sets overrun[0]=1; after out_ready=1, the delivered words are 0x01 then 0x03.
  - overrun_clr then clears the flag. Without DSYNC_OVERRUN_EN, overrun stays 0 throughout.
- Assert RST=0 for 1 cycle while out_valid=1 with two channels pending: on the next edge every output is 0 and no further words are delivered.

Source files
------------

// File: rtl/multi_channel_data_sync_if.sv
// Bus bundle for multi_channel_data_sync: per-channel source side plus the merged
// valid/ready stream. slave = the synchronizer, master = whoever drives the sources.
interface multi_channel_data_sync_if #(
  parameter int BUS_WIDTH = 8,
  parameter int NUM_CH    = 4,
  parameter int CH_W      = $clog2(NUM_CH)
);
  logic [NUM_CH*BUS_WIDTH-1:0] Unsync_bus;
  logic [NUM_CH-1:0]           bus_enable;
  logic                        toggle_mode;
  logic                        out_ready;
  logic                        overrun_clr;
  logic [NUM_CH*BUS_WIDTH-1:0] sync_bus;
  logic [NUM_CH-1:0]           enable_pulse;
  logic                        out_valid;
  logic [BUS_WIDTH-1:0]        out_data;
  logic [CH_W-1:0]             out_ch;
  logic [NUM_CH-1:0]           overrun;

  modport master (
    output Unsync_bus, bus_enable, toggle_mode, out_ready, overrun_clr,
    input  sync_bus, enable_pulse, out_valid, out_data, out_ch, overrun
  );
  modport slave (
    input  Unsync_bus, bus_enable, toggle_mode, out_ready, overrun_clr,
    output sync_bus, enable_pulse, out_valid, out_data, out_ch, overrun
  );
endinterface

// File: rtl/multi_channel_data_sync.sv
// NUM_CH-channel enable synchronizer with per-channel capture and a round-robin merged stream.
// Define DSYNC_OVERRUN_EN to build the sticky overrun flags and overrun_clr handling.

module multi_channel_data_sync_lane #(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 bus_enable,
  input  logic [BUS_WIDTH-1:0] din,
  input  logic                 toggle_mode,
  input  logic                 grant,
  input  logic                 overrun_clr,
  output logic [BUS_WIDTH-1:0] dout,
  output logic                 pulse,
  output logic                 pending,
  output logic                 overrun
);
  // Bit NUM_STAGES-1 is the synchronized enable, bit NUM_STAGES is its one-cycle-old copy.
  logic [NUM_STAGES:0] vld_pipe;
  logic sync, prev, ev;

  assign sync = vld_pipe[NUM_STAGES-1];
  assign prev = vld_pipe[NUM_STAGES];
  assign ev   = toggle_mode ? (sync ^ prev) : (sync & ~prev);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      vld_pipe <= '0;
      pulse    <= 1'b0;
      dout     <= '0;
      pending  <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[NUM_STAGES-1:0], bus_enable};
      pulse    <= ev;
      if (ev) dout <= din;
      // A new word outranks the grant of the old one, so it stays pending.
      if (ev)         pending <= 1'b1;
      else if (grant) pending <= 1'b0;
    end
  end

`ifdef DSYNC_OVERRUN_EN
  always_ff @(posedge CLK) begin
    if (!RST)                        overrun <= 1'b0;
    else if (ev && pending && !grant) overrun <= 1'b1;
    else if (overrun_clr)            overrun <= 1'b0;
  end
`else
  logic unused_clr;
  assign unused_clr = overrun_clr;
  assign overrun    = 1'b0;
`endif
endmodule

module multi_channel_data_sync #(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 2,
  parameter int NUM_CH     = 4,
  parameter int CH_W       = $clog2(NUM_CH)
) (
  input logic                       CLK,
  input logic                       RST,
  multi_channel_data_sync_if.slave  bus
);
  logic [NUM_CH-1:0][BUS_WIDTH-1:0] din, sb;
  logic [NUM_CH-1:0]                pulse, pend, ovr, grant;
  logic                             out_valid_q, load, gnt_vld;
  logic [BUS_WIDTH-1:0]             out_data_q;
  logic [CH_W-1:0]                  out_ch_q, rr_ptr, gnt_idx, cand;

  assign din              = bus.Unsync_bus;
  assign bus.sync_bus     = sb;
  assign bus.enable_pulse = pulse;
  assign bus.overrun      = ovr;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_ch       = out_ch_q;

  assign load = ~out_valid_q | bus.out_ready;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    assign grant[c] = load & gnt_vld & (gnt_idx == CH_W'(c));
    multi_channel_data_sync_lane #(
      .BUS_WIDTH (BUS_WIDTH),
      .NUM_STAGES(NUM_STAGES)
    ) u_lane (
      .CLK        (CLK),
      .RST        (RST),
      .bus_enable (bus.bus_enable[c]),
      .din        (din[c]),
      .toggle_mode(bus.toggle_mode),
      .grant      (grant[c]),
      .overrun_clr(bus.overrun_clr),
      .dout       (sb[c]),
      .pulse      (pulse[c]),
      .pending    (pend[c]),
      .overrun    (ovr[c])
    );
  end

  // Scan from farthest to nearest so the channel right after rr_ptr is the last (winning) hit.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      cand = CH_W'((int'(rr_ptr) + i) % NUM_CH);
      if (pend[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr      <= CH_W'(NUM_CH - 1);
    end else if (load) begin
      out_valid_q <= gnt_vld;
      if (gnt_vld) begin
        out_data_q <= sb[gnt_idx];
        out_ch_q   <= gnt_idx;
        rr_ptr     <= gnt_idx;
      end
    end
  end
endmodule

// File: tb/tb_multi_channel_data_sync.sv
// Bench for multi_channel_data_sync: directed scenarios plus random traffic, all checked
// every cycle against a behavioural model driven by the enable sample history.
module tb_multi_channel_data_sync;
  localparam int BW = 8, NS = 2, NCH = 4, CHW = $clog2(NCH), HLEN = 64;
`ifdef DSYNC_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic CLK, RST;
  multi_channel_data_sync_if #(.BUS_WIDTH(BW), .NUM_CH(NCH)) dif();
  multi_channel_data_sync #(.BUS_WIDTH(BW), .NUM_STAGES(NS), .NUM_CH(NCH)) dut (
    .CLK(CLK), .RST(RST), .bus(dif)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks = 0, failures = 0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: enable samples per edge; an event is seen NS edges after the edge that sampled it.
  logic hist [NCH][HLEN];
  int   cyc = 0, rst_at = -1;
  bit   model_ok = 1'b0;
  logic [NCH-1:0][BW-1:0] m_sb;
  logic [NCH-1:0] m_pulse, m_pend, m_ovr;
  logic m_ov;
  logic [BW-1:0]  m_od;
  logic [CHW-1:0] m_och;
  int   m_rr;

  function automatic logic val(int c, int i);
    if (i <= rst_at) return 1'b0;
    return hist[c][i % HLEN];
  endfunction

  always @(posedge CLK) begin
    logic [NCH-1:0][BW-1:0] din;
    logic s, p, ev;
    int g;
    cyc++;
    if (!RST) begin
      rst_at = cyc; model_ok = 1'b1;
      m_sb = '0; m_pulse = '0; m_pend = '0; m_ovr = '0;
      m_ov = 1'b0; m_od = '0; m_och = '0; m_rr = NCH - 1;
    end else begin
      din = dif.Unsync_bus;
      for (int c = 0; c < NCH; c++) hist[c][cyc % HLEN] = dif.bus_enable[c];
      g = -1;
      if (!m_ov || dif.out_ready) begin
        for (int i = 1; i <= NCH; i++)
          if (g < 0 && m_pend[(m_rr + i) % NCH]) g = (m_rr + i) % NCH;
        m_ov = (g >= 0);
        if (g >= 0) begin m_od = m_sb[g]; m_och = CHW'(g); m_rr = g; end
      end
      for (int c = 0; c < NCH; c++) begin
        s  = val(c, cyc - NS);
        p  = val(c, cyc - NS - 1);
        ev = dif.toggle_mode ? (s ^ p) : (s & ~p);
        m_pulse[c] = ev;
        if (dif.overrun_clr) m_ovr[c] = 1'b0;
        if (ev) begin
          if (OVR_EN && m_pend[c] && g != c) m_ovr[c] = 1'b1;
          m_sb[c] = din[c];
          m_pend[c] = 1'b1;
        end else if (g == c) m_pend[c] = 1'b0;
      end
    end
  end

  always @(negedge CLK) begin
    if (model_ok) begin
      chk("sync_bus", dif.sync_bus, m_sb);
      chk("enable_pulse", dif.enable_pulse, m_pulse);
      chk("out_valid", dif.out_valid, m_ov);
      chk("out_data", dif.out_data, m_od);
      chk("out_ch", dif.out_ch, m_och);
      chk("overrun", dif.overrun, m_ovr);
    end
  end

  // Delivered words and pulse counts, for the directed scenarios.
  logic [CHW-1:0] got_ch[$];
  logic [BW-1:0]  got_d[$];
  int pcnt [NCH];
  always @(posedge CLK) begin
    if (RST && dif.out_valid && dif.out_ready) begin
      got_ch.push_back(dif.out_ch);
      got_d.push_back(dif.out_data);
    end
    for (int c = 0; c < NCH; c++) if (dif.enable_pulse[c]) pcnt[c]++;
  end

  task automatic tick(int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic clear_log();
    got_ch.delete(); got_d.delete();
    for (int c = 0; c < NCH; c++) pcnt[c] = 0;
  endtask

  task automatic do_reset();
    RST = 1'b0; tick(1); RST = 1'b1;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_sync_bus"}, dif.sync_bus, 0);
    chk({tag, "_pulse"}, dif.enable_pulse, 0);
    chk({tag, "_valid"}, dif.out_valid, 0);
    chk({tag, "_data"}, dif.out_data, 0);
    chk({tag, "_ch"}, dif.out_ch, 0);
    chk({tag, "_overrun"}, dif.overrun, 0);
  endtask

  initial begin
    RST = 1'b0;
    dif.Unsync_bus = '0; dif.bus_enable = '0; dif.toggle_mode = 1'b0;
    dif.out_ready = 1'b1; dif.overrun_clr = 1'b0;
    tick(2);
    chk_all_zero("reset");
    RST = 1'b1;

    // Level mode, ch1 rises with 0xA5.
    dif.Unsync_bus[15:8] = 8'hA5; dif.bus_enable[1] = 1'b1;
    tick(2);
    chk("lvl_pulse_early", dif.enable_pulse, 4'b0000);
    tick(1);
    chk("lvl_pulse", dif.enable_pulse, 4'b0010);
    chk("lvl_sync_ch1", dif.sync_bus[15:8], 8'hA5);
    tick(1);
    chk("lvl_pulse_gone", dif.enable_pulse, 4'b0000);
    chk("lvl_valid", dif.out_valid, 1'b1);
    chk("lvl_data", dif.out_data, 8'hA5);
    chk("lvl_ch", dif.out_ch, 1);
    dif.bus_enable[1] = 1'b0;
    tick(6);

    // Toggle mode on ch2: both edges produce words.
    dif.toggle_mode = 1'b1; clear_log();
    dif.Unsync_bus[23:16] = 8'h11; dif.bus_enable[2] = 1'b1; tick(10);
    dif.Unsync_bus[23:16] = 8'h22; dif.bus_enable[2] = 1'b0; tick(10);
    chk("tgl_pulses", pcnt[2], 2);
    chk("tgl_words", got_d.size(), 2);
    if (got_d.size() == 2) begin
      chk("tgl_w0", {got_ch[0], got_d[0]}, {2'd2, 8'h11});
      chk("tgl_w1", {got_ch[1], got_d[1]}, {2'd2, 8'h22});
    end

    // Same pattern in level mode: only the rising edge counts.
    dif.toggle_mode = 1'b0; clear_log();
    dif.Unsync_bus[23:16] = 8'h11; dif.bus_enable[2] = 1'b1; tick(10);
    dif.Unsync_bus[23:16] = 8'h22; dif.bus_enable[2] = 1'b0; tick(10);
    chk("lvl2_pulses", pcnt[2], 1);
    chk("lvl2_words", got_d.size(), 1);
    if (got_d.size() == 1) chk("lvl2_w0", got_d[0], 8'h11);

    // Simultaneous events on ch0, ch1, ch3 from reset.
    do_reset();
    dif.Unsync_bus = 32'h3300_3130; dif.bus_enable = 4'b1011;
    tick(3);
    chk("sim_pulse", dif.enable_pulse, 4'b1011);
    tick(1); chk("sim_a", {dif.out_valid, dif.out_ch, dif.out_data}, {1'b1, 2'd0, 8'h30});
    tick(1); chk("sim_b", {dif.out_valid, dif.out_ch, dif.out_data}, {1'b1, 2'd1, 8'h31});
    tick(1); chk("sim_c", {dif.out_valid, dif.out_ch, dif.out_data}, {1'b1, 2'd3, 8'h33});
    tick(1); chk("sim_idle", dif.out_valid, 1'b0);
    dif.bus_enable = '0; tick(6);

    // Back-pressure and overrun on ch0 (toggle mode for repeated events).
    do_reset();
    dif.toggle_mode = 1'b1; dif.out_ready = 1'b0;
    dif.Unsync_bus[7:0] = 8'h01; dif.bus_enable[0] = 1'b1; tick(6);
    dif.Unsync_bus[7:0] = 8'h02; dif.bus_enable[0] = 1'b0; tick(6);
    chk("bp_valid", dif.out_valid, 1'b1);
    chk("bp_hold", dif.out_data, 8'h01);
    chk("bp_no_ovr", dif.overrun, 4'b0000);
    dif.Unsync_bus[7:0] = 8'h03; dif.bus_enable[0] = 1'b1; tick(6);
    chk("bp_ovr", dif.overrun, {3'b000, OVR_EN});
    clear_log();
    dif.out_ready = 1'b1; tick(4);
    chk("bp_words", got_d.size(), 2);
    if (got_d.size() == 2) begin
      chk("bp_w0", got_d[0], 8'h01);
      chk("bp_w1", got_d[1], 8'h03);
    end
    dif.overrun_clr = 1'b1; tick(1); dif.overrun_clr = 1'b0; tick(1);
    chk("bp_clr", dif.overrun, 4'b0000);

    // Reset mid-transfer with two words still pending.
    do_reset();
    dif.toggle_mode = 1'b0; dif.out_ready = 1'b0;
    dif.Unsync_bus = 32'h0042_4140; dif.bus_enable = 4'b0111; tick(6);
    chk("mid_valid", {dif.out_valid, dif.out_ch}, {1'b1, 2'd0});
    RST = 1'b0; dif.bus_enable = '0; tick(1); RST = 1'b1;
    chk_all_zero("mid_rst");
    clear_log(); dif.out_ready = 1'b1; tick(6);
    chk("mid_words", got_d.size(), 0);
    chk("mid_idle", dif.out_valid, 1'b0);

    // Random traffic; second half starves the consumer to provoke overruns.
    for (int n = 0; n < 1500; n++) begin
      if (n % 64 == 0) dif.toggle_mode = 1'($urandom_range(0, 1));
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 5) == 0) dif.bus_enable[c] = ~dif.bus_enable[c];
      dif.Unsync_bus  = $urandom;
      dif.out_ready   = (n < 750) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      dif.overrun_clr = ($urandom_range(0, 15) == 0);
      RST             = ($urandom_range(0, 199) != 0);
      tick(1);
    end
    RST = 1'b1; dif.overrun_clr = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
